dcache_wb: RTL and testbench
============================

DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 The block SHALL use clock clk and reset rst_n (synchronous, active-low).
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  clock
 rst_n  in  1  synchronous active-low reset
 proc_read  in  1  pipeline load request, held stable while proc_stall=1
 proc_write  in  1  pipeline store request, held stable while proc_stall=1
 proc_addr  in  30  word address
 proc_wdata  in  32  store data
 proc_stall  out  1  request not yet complete
 proc_rdata  out  32  load data, valid when proc_read=1 and proc_stall=0
 mem_read  out  1  line fill request
 mem_write  out  1  line write-back request
 mem_addr  out  28  line address
 mem_wdata  out  128  write-back line data
 mem_rdata  in  128  fill line data, valid with mem_ready
 mem_ready  in  1  one-cycle completion pulse from memory
REQ-003 Parameters, one per line (name, default, meaning): LINES, 8, number of cache lines; WORDS, 4, 32-bit words per line.

Function
REQ-004 Organisation SHALL be direct-mapped, write-back, write-allocate; offset=proc_addr[1:0], index=proc_addr[4:2], tag=proc_addr[29:5] (25 bits).
REQ-005 Each line SHALL hold valid, dirty, tag and 128 data bits; word k SHALL occupy bits [32k+31:32k]; data is stored unmodified, with no byte swapping.
REQ-006 Hit SHALL be defined as valid[index] & (tag_array[index]==tag).
REQ-007 FSM states SHALL be COMPARE (reset state), WRITEBACK and ALLOCATE.
REQ-008 COMPARE with no request SHALL change no state and drive proc_stall=0.
REQ-009 COMPARE with a read hit SHALL drive proc_rdata combinationally with the selected word and proc_stall=0, giving 0-cycle added latency.
REQ-010 COMPARE with a write hit SHALL drive proc_stall=0 and, at the next clk edge, write proc_wdata into the selected word and set dirty.
REQ-011 COMPARE with a miss where the line is not dirty (or not valid) SHALL go to ALLOCATE; with a miss where the line is valid and dirty, it SHALL go to WRITEBACK.
REQ-012 WRITEBACK SHALL drive mem_write=1, mem_addr={stored tag, index} and mem_wdata=line; on mem_ready=1 it SHALL go to ALLOCATE.
REQ-013 ALLOCATE SHALL drive mem_read=1 and mem_addr={tag, index}; on mem_ready=1 it SHALL load mem_rdata, set valid=1, dirty=0, update the tag and go to COMPARE, where the held request then hits.
REQ-014 mem_read and mem_write SHALL be decoded from state only (Moore), SHALL never be high together, and SHALL stay high through the mem_ready cycle.
REQ-015 proc_stall SHALL equal (proc_read|proc_write) & ~(state==COMPARE & hit).
REQ-016 If proc_read and proc_write are both high, the request SHALL be treated as a write; proc_rdata is then don't-care.
REQ-017 mem_ready while in COMPARE SHALL be ignored.
REQ-018 Back-to-back hits SHALL complete one per cycle; a miss to a clean line SHALL cost the memory latency plus 1 cycle; a dirty miss SHALL cost 2x the memory latency plus 1 cycle.

Reset
REQ-019 While rst_n=0 at a clk edge, the block SHALL set state=COMPARE and clear all valid and dirty bits; tag and data arrays are not reset.
REQ-020 Reset outputs SHALL be mem_read=0 and mem_write=0, with proc_stall following REQ-015 (it is 1 if a request is present, since every line is a miss).
REQ-021 Reset during WRITEBACK or ALLOCATE SHALL abandon the transfer; dirty data is lost and mem_read/mem_write drop on the following cycle.

Structure
REQ-022 Package dcache_wb_pkg SHALL hold LINES, WORDS, TAG_W=25, IDX_W=3, OFF_W=2 and the state enum.
REQ-023 Storage SHALL be a sub-module dcache_wb_array: valid/dirty/tag/data registers with a word-write port and a line-fill port; FSM and hit logic stay in dcache_wb.

Verification
REQ-024 After reset, read addr 0x0000010 with memory latency 4 -> mem_read high 5 cycles, mem_addr=0x0000004, proc_stall low the cycle after mem_ready, proc_rdata = fill word 0.
REQ-025 Write 0xDEADBEEF to addr 0x0000011 after that line is filled -> proc_stall=0, and a read of 0x0000011 on the next cycle returns 0xDEADBEEF.
REQ-026 Read 0x0000031 (same index 4, tag 1) while the dirty line from REQ-025 is present -> mem_write with mem_addr=0x0000004 and word1=0xDEADBEEF, then mem_read with mem_addr=0x000000C, never both high at once.
REQ-027 Four consecutive read hits to one line -> proc_stall low in all 4 cycles and mem_read/mem_write stay 0.
REQ-028 rst_n=0 asserted in the 2nd cycle of ALLOCATE -> mem_read=0 the next cycle, and a re-read of the same address misses again.

Source files
------------

// File: rtl/dcache_wb_pkg.sv
// Shared geometry and FSM state type for the write-back data cache.
package dcache_wb_pkg;

  localparam int unsigned LINES = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned TAG_W = 25;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned OFF_W = 2;

  typedef enum logic [1:0] {
    StCompare,
    StWriteback,
    StAllocate
  } state_e;

endpackage

// File: rtl/dcache_wb_array.sv
// Line storage for the cache: valid/dirty/tag/data per line, with a single-word
// store port and a whole-line fill port. Reads are asynchronous on idx.
module dcache_wb_array
  import dcache_wb_pkg::*;
#(
  parameter int unsigned LINES = dcache_wb_pkg::LINES,
  parameter int unsigned WORDS = dcache_wb_pkg::WORDS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IDX_W-1:0]            idx,
  output logic                        line_valid,
  output logic                        line_dirty,
  output logic [TAG_W-1:0]            line_tag,
  output logic [WORDS-1:0][31:0]      line_data,
  input  logic                        word_we,
  input  logic [OFF_W-1:0]            word_off,
  input  logic [31:0]                 word_data,
  input  logic                        fill_we,
  input  logic [TAG_W-1:0]            fill_tag,
  input  logic [WORDS-1:0][31:0]      fill_data
);

  logic [LINES-1:0]         valid_q;
  logic [LINES-1:0]         dirty_q;
  logic [TAG_W-1:0]         tag_q  [LINES];
  logic [WORDS-1:0][31:0]   data_q [LINES];

  // Status bits: cleared by reset; a fill makes the line clean, a store makes it dirty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data payload: not reset, contents only meaningful when valid.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (word_we) begin
      data_q[idx][word_off] <= word_data;
    end
  end

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
  assign line_tag   = tag_q[idx];
  assign line_data  = data_q[idx];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete in the
// request cycle; misses stall while the FSM writes back a dirty victim and
// fills the line, after which the held request hits.
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int unsigned LINES = dcache_wb_pkg::LINES,
  parameter int unsigned WORDS = dcache_wb_pkg::WORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     proc_read,
  input  logic                     proc_write,
  input  logic [29:0]              proc_addr,
  input  logic [31:0]              proc_wdata,
  output logic                     proc_stall,
  output logic [31:0]              proc_rdata,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [TAG_W+IDX_W-1:0]   mem_addr,
  output logic [WORDS*32-1:0]      mem_wdata,
  input  logic [WORDS*32-1:0]      mem_rdata,
  input  logic                     mem_ready
);

  logic [OFF_W-1:0]       off;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   req;
  logic                   hit;
  logic                   line_valid;
  logic                   line_dirty;
  logic [TAG_W-1:0]       line_tag;
  logic [WORDS-1:0][31:0] line_data;
  logic                   word_we;
  logic                   fill_we;
  state_e                 state_q, state_d;

  assign off = proc_addr[OFF_W-1:0];
  assign idx = proc_addr[OFF_W +: IDX_W];
  assign tag = proc_addr[OFF_W+IDX_W +: TAG_W];
  assign req = proc_read | proc_write;
  assign hit = line_valid & (line_tag == tag);

  dcache_wb_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (idx),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .word_we    (word_we),
    .word_off   (off),
    .word_data  (proc_wdata),
    .fill_we    (fill_we),
    .fill_tag   (tag),
    .fill_data  (mem_rdata)
  );

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StCompare;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, memory handshake (Moore) and array write enables.
  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {tag, idx};
    word_we   = 1'b0;
    fill_we   = 1'b0;
    unique case (state_q)
      StCompare: begin
        if (req && !hit) begin
          state_d = (line_valid && line_dirty) ? StWriteback : StAllocate;
        end else begin
          // Simultaneous read+write is handled as a write.
          word_we = proc_write;
        end
      end
      StWriteback: begin
        mem_write = 1'b1;
        mem_addr  = {line_tag, idx};
        if (mem_ready) begin
          state_d = StAllocate;
        end
      end
      StAllocate: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          fill_we = 1'b1;
          state_d = StCompare;
        end
      end
      default: state_d = StCompare;
    endcase
  end

  assign proc_stall = req & ~((state_q == StCompare) & hit);
  assign proc_rdata = line_data[off];
  assign mem_wdata  = line_data;

endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: the driver queues expected events before each
// request, the monitor pops and compares on every completion or memory handshake.
module tb_dcache_wb;

  localparam int LAT = 4;

  logic          clk;
  logic          rst_n;
  logic          proc_read;
  logic          proc_write;
  logic [29:0]   proc_addr;
  logic [31:0]   proc_wdata;
  logic          proc_stall;
  logic [31:0]   proc_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;

  typedef struct {
    int           kind;  // 0 proc read, 1 proc write, 2 line fill, 3 write-back
    logic [27:0]  addr;
    logic [127:0] data;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  armed  = 0;
  int  rd_run = 0;
  int  last_rd_run = 0;
  int  mem_act = 0;

  dcache_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  function automatic void expect_ev(input int k, input logic [27:0] a, input logic [127:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endfunction

  function automatic void match(input int k, input logic [27:0] a, input logic [127:0] d,
                                input bit chk_a, input bit chk_d);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got event kind %0d addr %h, expected none", k, a);
    end else begin
      e = sb.pop_front();
      check("sb_kind", k, e.kind);
      if (chk_a) check("sb_addr", a, e.addr);
      if (chk_d) check("sb_data", d, e.data);
    end
  endfunction

  // Memory: each fill word is 0xA0000000 | line_addr<<4 | word.
  function automatic logic [127:0] fill_line(input logic [27:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = 32'hA000_0000 | {a, 4'h0} | k;
    return l;
  endfunction

  // Memory model: mem_ready pulses in the (LAT+1)th cycle of a transfer.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end
      if (mem_read || mem_write) begin
        cnt++;
        if (cnt == LAT + 1) begin
          mem_ready = 1'b1;
          if (mem_read) mem_rdata = fill_line(mem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares every completed request and memory handshake against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("mem_excl", mem_read & mem_write, 1'b0);
        if (mem_read || mem_write) mem_act++;
        if (mem_read) begin
          rd_run++;
        end else if (rd_run != 0) begin
          last_rd_run = rd_run;
          rd_run = 0;
        end
        if (rst_n && mem_ready && mem_write) match(3, mem_addr, mem_wdata, 1, 1);
        if (rst_n && mem_ready && mem_read) match(2, mem_addr, '0, 1, 0);
        if (rst_n && (proc_read || proc_write) && !proc_stall)
          match(proc_write ? 1 : 0, '0, {96'b0, proc_rdata}, 0, !proc_write);
      end
    end
  end

  // Issue one request at posedge+1 and hold it until it completes; returns stall cycles.
  task automatic req(input bit rd, input bit wr, input logic [29:0] a,
                     input logic [31:0] d, output int stalls);
    bit done;
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = d;
    stalls = 0;
    done = 0;
    while (!done && stalls < 64) begin
      @(negedge clk);
      if (proc_stall) stalls++;
      else done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: addr %h still stalled after %0d cycles, expected completion",
               a, stalls);
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int act0;
    rst_n = 1'b0;
    proc_read = 1'b0;
    proc_write = 1'b0;
    proc_addr = '0;
    proc_wdata = '0;

    // Reset: every line misses, no memory traffic.
    @(posedge clk);
    #1;
    proc_read = 1'b1;
    proc_addr = 30'h10;
    @(negedge clk);
    check("rst_stall_req", proc_stall, 1'b1);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    @(posedge clk);
    #1;
    proc_read = 1'b0;
    rst_n = 1'b1;
    armed = 1'b1;
    @(negedge clk);
    check("idle_stall", proc_stall, 1'b0);
    @(posedge clk);
    #1;

    // Cold read miss: fill of line 0x4.
    expect_ev(2, 28'h4, '0);
    expect_ev(0, '0, 128'hA000_0040);
    req(1, 0, 30'h10, '0, st);
    check("cold_stall_cycles", st, 6);
    check("cold_mem_read_cycles", last_rd_run, 5);

    // Write hit, then read it back next cycle.
    expect_ev(1, '0, '0);
    req(0, 1, 30'h11, 32'hDEAD_BEEF, st);
    check("wr_hit_stall", st, 0);
    expect_ev(0, '0, 128'hDEAD_BEEF);
    req(1, 0, 30'h11, '0, st);
    check("rd_after_wr_stall", st, 0);

    // Dirty conflict miss: write-back of line 0x4, then fill of line 0xC.
    expect_ev(3, 28'h4, 128'hA000_0043_A000_0042_DEAD_BEEF_A000_0040);
    expect_ev(2, 28'hC, '0);
    expect_ev(0, '0, 128'hA000_00C1);
    req(1, 0, 30'h31, '0, st);
    check("dirty_miss_stall_cycles", st, 11);

    // Four back-to-back read hits, no memory activity.
    act0 = mem_act;
    for (int i = 0; i < 4; i++) begin
      expect_ev(0, '0, 128'hA000_00C0 | i);
      req(1, 0, 30'h30 + i, '0, st);
      check("b2b_hit_stall", st, 0);
    end
    check("b2b_mem_idle", mem_act, act0);

    // Write miss allocates line 0x15, then the store lands.
    expect_ev(2, 28'h15, '0);
    expect_ev(1, '0, '0);
    req(0, 1, 30'h55, 32'h1234_5678, st);
    check("wr_miss_stall_cycles", st, 6);
    expect_ev(0, '0, 128'h1234_5678);
    req(1, 0, 30'h55, '0, st);
    expect_ev(0, '0, 128'hA000_0150);
    req(1, 0, 30'h54, '0, st);

    // Clean victim (filled, never written): fill only, no write-back.
    expect_ev(2, 28'h4, '0);
    expect_ev(0, '0, 128'hA000_0040);
    req(1, 0, 30'h10, '0, st);
    check("clean_miss_stall_cycles", st, 6);

    // Reset in the 2nd ALLOCATE cycle abandons the fill.
    proc_read = 1'b1;
    proc_addr = 30'h70;
    @(negedge clk);
    check("r28_miss_stall", proc_stall, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("r28_alloc_read", mem_read, 1'b1);
    check("r28_alloc_addr", mem_addr, 28'h1C);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    proc_read = 1'b0;
    @(negedge clk);
    check("r28_read_dropped", mem_read, 1'b0);
    @(posedge clk);
    #1;
    expect_ev(2, 28'h1C, '0);
    expect_ev(0, '0, 128'hA000_01C0);
    req(1, 0, 30'h70, '0, st);
    check("r28_remiss_stall_cycles", st, 6);

    // Read and write together act as a write.
    expect_ev(1, '0, '0);
    req(1, 1, 30'h72, 32'hCAFE_F00D, st);
    check("rw_both_stall", st, 0);
    expect_ev(0, '0, 128'hCAFE_F00D);
    req(1, 0, 30'h72, '0, st);

    repeat (2) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
